// File: rtl/wb_fetch_pkg.sv
// rtl/wb_fetch_pkg.sv - shared widths, FSM states and fault-cause encodings for the fetcher
package wb_fetch_pkg;

  localparam int          WB_ADR_WIDTH = 64;
  localparam int          WB_DAT_WIDTH = 64;
  localparam logic [63:0] WB_RESET_PC  = 64'h0000_8000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_WAIT,
    ST_FAULT
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_BUS_ERR  = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_MISALIGN = 2'b11
  } fault_cause_e;

  // Instruction words are 8 bytes wide; any low address bit set is illegal.
  function automatic logic is_misaligned(input logic [2:0] adr_lo);
    return adr_lo != 3'b000;
  endfunction

endpackage

// File: rtl/wb_fetch_if.sv
// rtl/wb_fetch_if.sv - Wishbone read-port bundle between the fetcher and the interconnect
interface wb_fetch_if
  import wb_fetch_pkg::*;
#(
  parameter int ADR_WIDTH = WB_ADR_WIDTH,
  parameter int DAT_WIDTH = WB_DAT_WIDTH
);
  logic [ADR_WIDTH-1:0] fetch_adr_o;
  logic [DAT_WIDTH-1:0] fetch_dat_o;
  logic [DAT_WIDTH-1:0] fetch_dat_i;
  logic                 fetch_we_o;
  logic                 fetch_cyc_o;
  logic                 fetch_stb_o;
  logic                 fetch_ack_i;
  logic                 fetch_err_i;

  modport master (
    output fetch_adr_o, fetch_dat_o, fetch_we_o, fetch_cyc_o, fetch_stb_o,
    input  fetch_dat_i, fetch_ack_i, fetch_err_i
  );

  modport slave (
    input  fetch_adr_o, fetch_dat_o, fetch_we_o, fetch_cyc_o, fetch_stb_o,
    output fetch_dat_i, fetch_ack_i, fetch_err_i
  );
endinterface

// File: rtl/wb_fetch_buffer.sv
// rtl/wb_fetch_buffer.sv - one-entry valid/ready holding register for a fetched instruction and its pc
module wb_fetch_buffer #(
  parameter int ADR_WIDTH = 64,
  parameter int DAT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fill_i,
  input  logic                 flush_i,
  input  logic [DAT_WIDTH-1:0] insn_i,
  input  logic [ADR_WIDTH-1:0] pc_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DAT_WIDTH-1:0] insn_o,
  output logic [ADR_WIDTH-1:0] insn_pc_o
);

  // Flush beats fill so a redirect drops the response captured in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      insn_o    <= '0;
      insn_pc_o <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (fill_i) begin
      valid_o   <= 1'b1;
      insn_o    <= insn_i;
      insn_pc_o <= pc_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_fetch.sv
// rtl/wb_fetch.sv - Wishbone master instruction fetcher with redirect and fault latching
module wb_fetch
  import wb_fetch_pkg::*;
#(
  parameter int                   ADR_WIDTH = WB_ADR_WIDTH,
  parameter int                   DAT_WIDTH = WB_DAT_WIDTH,
  parameter logic [ADR_WIDTH-1:0] RESET_PC  = WB_RESET_PC,
  parameter int                   TIMEOUT   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_fetch_if.master           bus,
  output logic [DAT_WIDTH-1:0] insn_o,
  output logic [ADR_WIDTH-1:0] insn_pc_o,
  output logic                 insn_valid_o,
  input  logic                 insn_ready_i,
  input  logic                 redirect_i,
  input  logic [ADR_WIDTH-1:0] redirect_pc_i,
  output logic                 fault_o,
  output logic [1:0]           fault_cause_o,
  output logic [ADR_WIDTH-1:0] fault_pc_o
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

  fetch_state_e         state_q, state_d;
  logic [ADR_WIDTH-1:0] pc_q, pc_d, fault_pc_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  fault_cause_e         cause_q, cause_d;
  logic                 fault_d;
  logic                 stb_q;
  logic                 fill, flush, buf_go;

  assign buf_go = !insn_valid_o || insn_ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tcnt_d     = tcnt_q;
    fault_d    = fault_o;
    cause_d    = cause_q;
    fault_pc_d = fault_pc_o;
    fill       = 1'b0;
    flush      = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (tcnt_q != T_MAX) tcnt_d = tcnt_q + 1'b1;
        if (bus.fetch_err_i) begin
          state_d    = ST_FAULT;
          fault_d    = 1'b1;
          cause_d    = CAUSE_BUS_ERR;
          fault_pc_d = pc_q;
        end else if (bus.fetch_ack_i) begin
          fill    = 1'b1;
          pc_d    = pc_q + ADR_WIDTH'(8);
          state_d = ST_GAP;
        end else if (tcnt_q == T_LAST) begin
          state_d    = ST_FAULT;
          fault_d    = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
          fault_pc_d = pc_q;
        end
      end
      ST_GAP, ST_WAIT: state_d = buf_go ? ST_REQ : ST_WAIT;
      ST_FAULT: state_d = ST_FAULT;
      default: state_d = ST_IDLE;
    endcase

    // A redirect overrides whatever the state logic above decided this cycle.
    if (redirect_i) begin
      pc_d  = redirect_pc_i;
      flush = 1'b1;
      fill  = 1'b0;
      if (is_misaligned(redirect_pc_i[2:0])) begin
        state_d    = ST_FAULT;
        fault_d    = 1'b1;
        cause_d    = CAUSE_MISALIGN;
        fault_pc_d = redirect_pc_i;
      end else begin
        fault_d    = 1'b0;
        cause_d    = cause_q;
        fault_pc_d = fault_pc_o;
        state_d    = (state_q == ST_GAP || state_q == ST_WAIT) ? ST_REQ : ST_GAP;
      end
    end

    if (state_d == ST_REQ && state_q != ST_REQ) tcnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      tcnt_q     <= '0;
      stb_q      <= 1'b0;
      fault_o    <= 1'b0;
      cause_q    <= CAUSE_NONE;
      fault_pc_o <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tcnt_q     <= tcnt_d;
      stb_q      <= (state_d == ST_REQ);
      fault_o    <= fault_d;
      cause_q    <= cause_d;
      fault_pc_o <= fault_pc_d;
    end
  end

  assign fault_cause_o   = cause_q;
  assign bus.fetch_adr_o = pc_q;
  assign bus.fetch_dat_o = '0;
  assign bus.fetch_we_o  = 1'b0;
  assign bus.fetch_cyc_o = stb_q;
  assign bus.fetch_stb_o = stb_q;

  wb_fetch_buffer #(
    .ADR_WIDTH (ADR_WIDTH),
    .DAT_WIDTH (DAT_WIDTH)
  ) u_buffer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .fill_i    (fill),
    .flush_i   (flush),
    .insn_i    (bus.fetch_dat_i),
    .pc_i      (pc_q),
    .ready_i   (insn_ready_i),
    .valid_o   (insn_valid_o),
    .insn_o    (insn_o),
    .insn_pc_o (insn_pc_o)
  );

endmodule

// File: tb/tb_wb_fetch.sv
// tb/tb_wb_fetch.sv - directed self-checking bench for wb_fetch against a registered-ack ROM slave
module tb_wb_fetch;

  localparam logic [63:0] BASE = 64'h0000_8000_0000_0000;
  localparam logic [63:0] W0   = 64'h0280401002000010;
  localparam logic [63:0] W1   = 64'h0280800000000e60;
  localparam logic [63:0] W28  = 64'h0400c20000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        insn_ready, redirect, insn_valid, fault;
  logic [63:0] redirect_pc, insn, insn_pc, fault_pc;
  logic [1:0]  cause;
  logic        noresp;
  logic [63:0] err_adr;
  logic        stb_prev;
  int          n_req = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] acc_insn[$];
  logic [63:0] acc_pc[$];

  always #5 clk = ~clk;

  wb_fetch_if #(.ADR_WIDTH(64), .DAT_WIDTH(64)) bus ();

  wb_fetch #(
    .ADR_WIDTH (64),
    .DAT_WIDTH (64),
    .RESET_PC  (BASE),
    .TIMEOUT   (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .insn_o        (insn),
    .insn_pc_o     (insn_pc),
    .insn_valid_o  (insn_valid),
    .insn_ready_i  (insn_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .fault_o       (fault),
    .fault_cause_o (cause),
    .fault_pc_o    (fault_pc)
  );

  function automatic logic [63:0] rom(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    case (off)
      64'h00:  return W0;
      64'h08:  return W1;
      64'h28:  return W28;
      default: return {32'hCAFE_0000, a[31:0]};
    endcase
  endfunction

  // Registered slave: one ack/err per strobe, dropped once stb has been seen low.
  always @(posedge clk) begin
    if (rst) begin
      bus.fetch_ack_i <= 1'b0;
      bus.fetch_err_i <= 1'b0;
      bus.fetch_dat_i <= '0;
    end else begin
      bus.fetch_ack_i <= 1'b0;
      bus.fetch_err_i <= 1'b0;
      if (bus.fetch_cyc_o && bus.fetch_stb_o && !bus.fetch_ack_i && !bus.fetch_err_i && !noresp) begin
        if (bus.fetch_adr_o == err_adr) bus.fetch_err_i <= 1'b1;
        else begin
          bus.fetch_ack_i <= 1'b1;
          bus.fetch_dat_i <= rom(bus.fetch_adr_o);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) stb_prev <= 1'b0;
    else begin
      if (bus.fetch_stb_o && !stb_prev) n_req <= n_req + 1;
      stb_prev <= bus.fetch_stb_o;
      if (insn_valid && insn_ready) begin
        acc_insn.push_back(insn);
        acc_pc.push_back(insn_pc);
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, " stb"}, bus.fetch_stb_o, 1'b0);
    chk1({tag, " cyc"}, bus.fetch_cyc_o, 1'b0);
    chk1({tag, " we"}, bus.fetch_we_o, 1'b0);
    chkw({tag, " dat_o"}, bus.fetch_dat_o, 64'h0);
    chkw({tag, " adr"}, bus.fetch_adr_o, BASE);
    chk1({tag, " valid"}, insn_valid, 1'b0);
    chkw({tag, " insn"}, insn, 64'h0);
    chkw({tag, " insn_pc"}, insn_pc, 64'h0);
    chk1({tag, " fault"}, fault, 1'b0);
    chk2({tag, " cause"}, cause, 2'b00);
    chkw({tag, " fault_pc"}, fault_pc, 64'h0);
  endtask

  initial begin
    int n;
    insn_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    noresp      = 1'b0;
    err_adr     = BASE + 64'h10;
    step(3);
    chk_reset("reset");
    rst = 1'b0;

    // Sequential fetch with stb high, high, low
    step(1); chk1("seq c1 stb", bus.fetch_stb_o, 1'b1); chkw("seq c1 adr", bus.fetch_adr_o, BASE);
    step(1); chk1("seq c2 stb", bus.fetch_stb_o, 1'b1); chk1("seq c2 ack", bus.fetch_ack_i, 1'b1);
    step(1); chk1("seq c3 stb", bus.fetch_stb_o, 1'b0); chk1("seq c3 valid", insn_valid, 1'b1);
    chkw("seq c3 insn", insn, W0); chkw("seq c3 insn_pc", insn_pc, BASE);
    chki("seq c3 nreq", n_req, 1);

    // Backpressure
    insn_ready = 1'b0;
    step(10);
    chk1("bp stb", bus.fetch_stb_o, 1'b0); chk1("bp valid", insn_valid, 1'b1);
    chkw("bp insn", insn, W0); chki("bp nreq", n_req, 1);
    insn_ready = 1'b1;
    step(1); chk1("bp2 stb", bus.fetch_stb_o, 1'b1); chkw("bp2 adr", bus.fetch_adr_o, BASE + 64'h8);
    chk1("bp2 valid", insn_valid, 1'b0);
    step(1); chk1("bp3 stb", bus.fetch_stb_o, 1'b1);
    step(1); chk1("bp4 stb", bus.fetch_stb_o, 1'b0); chkw("bp4 insn", insn, W1);
    chkw("bp4 insn_pc", insn_pc, BASE + 64'h8);

    // Bus error at +0x10
    step(1); chk1("err stb", bus.fetch_stb_o, 1'b1); chkw("err adr", bus.fetch_adr_o, BASE + 64'h10);
    step(1); chk1("err err_i", bus.fetch_err_i, 1'b1);
    step(1); chk1("err fault", fault, 1'b1); chk2("err cause", cause, 2'b01);
    chkw("err fault_pc", fault_pc, BASE + 64'h10); chk1("err stb low", bus.fetch_stb_o, 1'b0);
    step(5); chk1("err hold stb", bus.fetch_stb_o, 1'b0); chk1("err hold fault", fault, 1'b1);
    chki("err nreq", n_req, 3);

    // Redirect out of fault, then redirect in the ack cycle
    redirect = 1'b1; redirect_pc = BASE + 64'h18;
    step(1); redirect = 1'b0;
    chk1("rd fault clr", fault, 1'b0); chkw("rd adr", bus.fetch_adr_o, BASE + 64'h18);
    chk1("rd gap stb", bus.fetch_stb_o, 1'b0);
    step(1); chk1("rd req stb", bus.fetch_stb_o, 1'b1);
    step(1); chk1("rd ack", bus.fetch_ack_i, 1'b1);
    redirect = 1'b1; redirect_pc = BASE + 64'h28;
    step(1); redirect = 1'b0;
    chk1("rd2 stb", bus.fetch_stb_o, 1'b0); chk1("rd2 discard", insn_valid, 1'b0);
    chkw("rd2 adr", bus.fetch_adr_o, BASE + 64'h28);
    step(1); chk1("rd2 req stb", bus.fetch_stb_o, 1'b1);
    step(2); chk1("rd2 valid", insn_valid, 1'b1); chkw("rd2 insn", insn, W28);
    chkw("rd2 insn_pc", insn_pc, BASE + 64'h28);

    // Timeout on a silent slave
    noresp = 1'b1;
    step(1);
    chki("acc count", acc_insn.size(), 3);
    if (acc_insn.size() == 3) begin
      chkw("acc0", acc_insn[0], W0); chkw("acc1", acc_insn[1], W1); chkw("acc2", acc_insn[2], W28);
      chkw("acc2 pc", acc_pc[2], BASE + 64'h28);
    end
    n = 0;
    for (int i = 0; i < 40 && !fault; i++) begin
      if (bus.fetch_stb_o) n++;
      step(1);
    end
    chki("to req cycles", n, 16); chk1("to fault", fault, 1'b1); chk2("to cause", cause, 2'b10);
    chkw("to fault_pc", fault_pc, BASE + 64'h30);
    noresp = 1'b0;

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = BASE + 64'h2C;
    step(1); redirect = 1'b0;
    chk1("mis fault", fault, 1'b1); chk2("mis cause", cause, 2'b11);
    chkw("mis fault_pc", fault_pc, BASE + 64'h2C); chkw("mis adr", bus.fetch_adr_o, BASE + 64'h2C);
    step(5); chk1("mis stb", bus.fetch_stb_o, 1'b0); chki("mis nreq", n_req, 6);

    // pc wraps past the top of the address space
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    step(1); redirect = 1'b0; chk1("wrap fault clr", fault, 1'b0);
    step(1); chk1("wrap stb", bus.fetch_stb_o, 1'b1);
    step(2); chk1("wrap valid", insn_valid, 1'b1);
    chkw("wrap insn", insn, 64'hCAFE_0000_FFFF_FFF8); chkw("wrap adr", bus.fetch_adr_o, 64'h0);

    // Reset during REQ
    step(1); chk1("rst req stb", bus.fetch_stb_o, 1'b1);
    rst = 1'b1;
    step(1); chk_reset("midrst");
    rst = 1'b0;
    step(1); chk1("restart stb", bus.fetch_stb_o, 1'b1); chkw("restart adr", bus.fetch_adr_o, BASE);
    step(2); chk1("restart valid", insn_valid, 1'b1); chkw("restart insn", insn, W0);
    chkw("restart insn_pc", insn_pc, BASE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
